ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
//  Configuration-chain loader driving the ccff_head of a tile's routing-mux memory chain
//  (connection/switch block mem cells clocked by prog_clk). Accepts bitstream bytes over
//  valid/ready, serializes them MSB-first and emits exactly CHAIN_LEN bits with a per-bit
//  shift enable for prog_clk gating. Computes parity of the old contents pushed out of ccff_tail.
// PARAMETERS
//  CHAIN_LEN  6    total config bits in the downstream chain (3 size-2 muxes x 2 bits)
//  CNT_W      16   width of the bit counter; CHAIN_LEN < 2**CNT_W
//  TIMEOUT    255  max consecutive starved cycles in LOAD before error (>=1)
// PORTS
//  prog_clk       in   1      configuration clock, single clock domain
//  pReset         in   1      synchronous, active-high reset
//  start          in   1      pulse: begin a load (honoured in IDLE/DONE/ERR only)
//  cfg_data       in   8      bitstream byte, bit 7 shifted first
//  cfg_valid      in   1      cfg_data valid
//  cfg_ready      out  1      byte accepted when cfg_valid & cfg_ready at posedge
//  ccff_head      out  1      serial config bit into chain head (registered)
//  ccff_shift_en  out  1      1 = chain must shift this cycle (registered, gates prog_clk)
//  ccff_tail      in   1      chain tail, sampled only in cycles where ccff_shift_en=1
//  busy           out  1      state==LOAD
//  done           out  1      sticky: CHAIN_LEN bits shifted
//  err            out  1      sticky: starvation timeout
//  prev_parity    out  1      XOR of all ccff_tail bits sampled during the load
//  bits_sent      out  CNT_W  bits shifted so far
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (cfg_ready, ccff_head, ccff_shift_en, busy, done, err,
//   prev_parity, bits_sent, internal byte reg, bits_left, stall counter). Reset mid-load aborts
//   immediately; chain contents left as-is.
//  States: IDLE -start-> LOAD; LOAD -(bits_sent reaches CHAIN_LEN)-> DONE;
//   LOAD -(stall==TIMEOUT)-> ERR; DONE/ERR -start-> LOAD. start in LOAD ignored.
//  Entering LOAD: bits_sent, prev_parity, stall, bits_left cleared; done/err cleared.
//  Byte reg sr[7:0] + bits_left[3:0]. cfg_ready = LOAD & bits_left<=1 &
//   (bits_sent+bits_left < CHAIN_LEN) -> back-to-back bytes stream with no bubble.
//  Accept: sr<=cfg_data, bits_left<=8 (overrides the decrement of the same cycle).
//  Each LOAD cycle with bits_left>0: ccff_head<=sr[7], ccff_shift_en<=1, sr<<=1,
//   bits_left--, bits_sent++. Otherwise ccff_shift_en<=0, ccff_head holds value.
//  Latency: first bit appears on ccff_head/shift_en 2 cycles after accept edge (accept, then shift).
//  Sent bits cap at CHAIN_LEN: leftover bits of last byte discarded; bits_left cleared on exit.
//  prev_parity ^= ccff_tail in every cycle where ccff_shift_en==1 (old contents, CHAIN_LEN bits).
//  Stall counter: +1 per LOAD cycle with bits_left==0 and no accept; cleared on accept.
//   Reaching TIMEOUT -> ERR next cycle; err=1, shift_en=0, cfg_ready=0.
//  DONE entered the cycle after the last shift_en pulse is registered; done=1, cfg_ready=0.
//  bits_sent saturates at CHAIN_LEN; no wrap. Widths: bits_sent+bits_left computed in CNT_W+1.
// TESTING
//  1. Reset, start, one byte 0xA5 valid immediately -> ccff_head = 1,0,1,0,0,1 on 6
//     consecutive shift_en cycles, 0x?? bits 1..0 dropped, done=1, bits_sent=6, cfg_ready=0.
//  2. CHAIN_LEN=20, bytes 0xFF,0x00,0xF0 continuous -> 20 contiguous shift_en cycles, no bubble,
//     cfg_ready low after 3rd byte, done after 20 bits.
//  3. ccff_tail driven 1 on 3 of 6 shift cycles -> prev_parity=1; on 4 -> prev_parity=0;
//     tail toggled outside shift_en cycles ignored.
//  4. start, withhold cfg_valid TIMEOUT=4 cycles -> err=1, busy=0; new start clears err and
//     load completes normally.
//  5. pReset asserted after 3 bits shifted -> next cycle all outputs 0, IDLE; start in LOAD
//     and cfg_valid in IDLE have no effect.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Feeds the ccff_head of a tile's configuration-memory chain (the mem cells
//   behind the connection/switch-block routing muxes, clocked by prog_clk).
//   Bitstream bytes arrive over valid/ready, are serialized MSB-first and
//   exactly CHAIN_LEN bits are emitted, each qualified by ccff_shift_en so the
//   chain clock can be gated. The old chain contents falling out of ccff_tail
//   are folded into an XOR parity while the load runs.
//
//   Handshake: a byte transfers on a rising prog_clk edge where cfg_valid and
//   cfg_ready are both 1; cfg_ready is a combinational function of registered
//   state only and never depends on cfg_valid.
//
// Ports
//   prog_clk, pReset      clock, synchronous active-high reset
//   start                 begin a load (ignored while a load is running)
//   cfg_data/valid/ready  byte input stream, bit 7 is shifted first
//   ccff_head             registered serial bit into the chain head
//   ccff_shift_en         registered per-bit shift enable for the chain
//   ccff_tail             chain tail, sampled only while ccff_shift_en=1
//   busy, done, err       load running / completed / starved out
//   prev_parity           XOR of the tail bits seen during the load
//   bits_sent             bits shifted in the current/last load
//   dbg_state             current FSM state (IDLE=0, LOAD=1, DONE=2, ERR=3)
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 6,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic             prog_clk,
    input  logic             pReset,
    input  logic             start,
    input  logic [7:0]       cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    input  logic             ccff_tail,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             prev_parity,
    output logic [CNT_W-1:0] bits_sent,
    output logic [1:0]       dbg_state
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W:0]   LEN_X   = (CNT_W + 1)'(CHAIN_LEN);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]         sr;
    logic [3:0]         bits_left;
    logic [STALL_W-1:0] stall;

    logic               in_load;
    logic               accept;
    logic               can_shift;
    logic               chain_full;
    logic               enter_load;
    logic [CNT_W:0]     sent_x;
    logic [CNT_W:0]     committed;

    // Widened so the bits still queued in sr can be added without overflow.
    assign sent_x     = {1'b0, bits_sent};
    assign committed  = sent_x + {{(CNT_W - 3){1'b0}}, bits_left};

    assign in_load    = (state == S_LOAD);
    assign chain_full = (sent_x >= LEN_X);
    // Ready while the last queued bit is going out, so the next byte lands
    // exactly when it is needed; never ask for bits beyond CHAIN_LEN.
    assign cfg_ready  = in_load && (bits_left <= 4'd1) && (committed < LEN_X);
    assign accept     = cfg_ready && cfg_valid;
    assign can_shift  = in_load && (bits_left != 4'd0) && !chain_full;
    assign enter_load = (state != S_LOAD) && (state_nxt == S_LOAD);

    assign busy      = in_load;
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                // bits_sent reached CHAIN_LEN on the edge that registered the
                // final shift pulse, so DONE follows one cycle after it.
                if (chain_full)              state_nxt = S_DONE;
                else if (stall == STALL_MAX) state_nxt = S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state         <= S_IDLE;
            sr            <= 8'd0;
            bits_left     <= 4'd0;
            stall         <= '0;
            bits_sent     <= '0;
            prev_parity   <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
        end else begin
            state <= state_nxt;

            // The tail bit is valid in exactly the cycles the chain shifts.
            if (ccff_shift_en) prev_parity <= prev_parity ^ ccff_tail;

            if (enter_load) begin
                bits_sent     <= '0;
                prev_parity   <= 1'b0;
                stall         <= '0;
                bits_left     <= 4'd0;
                ccff_shift_en <= 1'b0;
            end else if (in_load) begin
                ccff_shift_en <= can_shift;
                if (can_shift) begin
                    ccff_head <= sr[7];
                    sr        <= {sr[6:0], 1'b0};
                    bits_left <= bits_left - 4'd1;
                    bits_sent <= bits_sent + CNT_W'(1);
                end
                // A new byte overrides the shift/decrement of the same edge.
                if (accept) begin
                    sr        <= cfg_data;
                    bits_left <= 4'd8;
                end

                if (accept)                  stall <= '0;
                else if (bits_left == 4'd0 && stall != STALL_MAX)
                    stall <= stall + STALL_W'(1);

                // Leftover bits of the final byte are dropped on exit.
                if (state_nxt != S_LOAD) bits_left <= 4'd0;
            end else begin
                ccff_shift_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 6-bit chain instance (TIMEOUT=4) and a
// 20-bit chain instance share the byte stream and the tail input.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start6 = 1'b0;
  logic start20 = 1'b0;
  logic [7:0] cfg_data = 8'd0;
  logic cfg_valid = 1'b0;
  logic ccff_tail = 1'b0;

  logic r6, h6, se6, busy6, done6, err6, par6;
  logic [15:0] bs6;
  logic [1:0] st6;
  logic r20, h20, se20, busy20, done20, err20, par20;
  logic [15:0] bs20;
  logic [1:0] st20;

  int n_checks = 0;
  int n_pass = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp20_q[$];
  int cyc = 0;
  int sh20_cnt = 0;
  int sh20_first = -1;
  int sh20_last = -1;
  logic [7:0] tail_pat = 8'd0;
  int tail_idx = 0;

  ccff_chain_loader #(.CHAIN_LEN(6), .CNT_W(16), .TIMEOUT(4)) u_dut6 (
    .prog_clk(clk), .pReset(rst), .start(start6),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(r6),
    .ccff_head(h6), .ccff_shift_en(se6), .ccff_tail(ccff_tail),
    .busy(busy6), .done(done6), .err(err6), .prev_parity(par6),
    .bits_sent(bs6), .dbg_state(st6)
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .CNT_W(16), .TIMEOUT(255)) u_dut20 (
    .prog_clk(clk), .pReset(rst), .start(start20),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(r20),
    .ccff_head(h20), .ccff_shift_en(se20), .ccff_tail(ccff_tail),
    .busy(busy20), .done(done20), .err(err20), .prev_parity(par20),
    .bits_sent(bs20), .dbg_state(st20)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // scoreboard monitor: pops one expected head bit per shift pulse
  always @(negedge clk) begin
    cyc++;
    if (se6) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL head6 unexpected shift: actual=%0b required=no_shift", h6);
      end else chk("head6", 32'(h6), 32'(exp_q.pop_front()));
    end
    if (se20) begin
      sh20_cnt++;
      if (sh20_first < 0) sh20_first = cyc;
      sh20_last = cyc;
      if (exp20_q.size() == 0) begin
        n_checks++;
        $display("FAIL head20 unexpected shift: actual=%0b required=no_shift", h20);
      end else chk("head20", 32'(h20), 32'(exp20_q.pop_front()));
    end
  end

  // tail driver: patterned bits on shift cycles, noise elsewhere
  always @(negedge clk) begin
    if (se6) begin
      ccff_tail = tail_pat[tail_idx[2:0]];
      tail_idx++;
    end else begin
      ccff_tail = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks
  task automatic push_bits(input logic [7:0] b, input int n, input int which);
    for (int i = 0; i < n; i++) begin
      if (which == 20) exp20_q.push_back(b[7-i]);
      else exp_q.push_back(b[7-i]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int which);
    logic rdy;
    int n;
    n = 0;
    cfg_data = b;
    cfg_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = (which == 20) ? r20 : r6;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 40);
    chk("accept", 32'(rdy), 32'd1);
  endtask

  task automatic pulse_start6();
    start6 = 1'b1;
    @(posedge clk);
    #1;
    start6 = 1'b0;
  endtask

  task automatic wait_end6(input int n);
    int k;
    k = 0;
    while (!(done6 || err6) && k < n) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(r6), 32'd0);
    chk({tag, "_head"}, 32'(h6), 32'd0);
    chk({tag, "_shift_en"}, 32'(se6), 32'd0);
    chk({tag, "_busy"}, 32'(busy6), 32'd0);
    chk({tag, "_done"}, 32'(done6), 32'd0);
    chk({tag, "_err"}, 32'(err6), 32'd0);
    chk({tag, "_parity"}, 32'(par6), 32'd0);
    chk({tag, "_bits_sent"}, 32'(bs6), 32'd0);
    chk({tag, "_state"}, 32'(st6), 32'd0);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 0xA5 into a 6-bit chain; tail has three ones -> parity 1
    tail_idx = 0;
    tail_pat = 8'b0000_1101;
    pulse_start6();
    chk("t1_busy", 32'(busy6), 32'd1);
    chk("t1_state", 32'(st6), 32'd1);
    push_bits(8'hA5, 6, 6);
    send_byte(8'hA5, 6);
    cfg_valid = 1'b0;
    wait_end6(30);
    chk("t1_done", 32'(done6), 32'd1);
    chk("t1_bits_sent", 32'(bs6), 32'd6);
    chk("t1_ready", 32'(r6), 32'd0);
    chk("t1_busy_end", 32'(busy6), 32'd0);
    chk("t1_state_end", 32'(st6), 32'd2);
    chk("t1_parity", 32'(par6), 32'd1);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // four tail ones -> parity 0
    tail_idx = 0;
    tail_pat = 8'b0011_0011;
    pulse_start6();
    chk("t3_done_cleared", 32'(done6), 32'd0);
    push_bits(8'h3C, 6, 6);
    send_byte(8'h3C, 6);
    cfg_valid = 1'b0;
    wait_end6(30);
    chk("t3_done", 32'(done6), 32'd1);
    chk("t3_parity", 32'(par6), 32'd0);

    // starvation: four stalled cycles then ERR on the fifth edge
    pulse_start6();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("t4_err_early", 32'(err6), 32'd0);
    chk("t4_busy_early", 32'(busy6), 32'd1);
    @(posedge clk);
    #1;
    chk("t4_err", 32'(err6), 32'd1);
    chk("t4_busy", 32'(busy6), 32'd0);
    chk("t4_state", 32'(st6), 32'd3);
    chk("t4_ready", 32'(r6), 32'd0);
    chk("t4_shift_en", 32'(se6), 32'd0);
    tail_idx = 0;
    tail_pat = 8'd0;
    pulse_start6();
    chk("t4_err_cleared", 32'(err6), 32'd0);
    chk("t4_restart_busy", 32'(busy6), 32'd1);
    chk("t4_restart_bits", 32'(bs6), 32'd0);
    push_bits(8'hC3, 6, 6);
    send_byte(8'hC3, 6);
    cfg_valid = 1'b0;
    wait_end6(30);
    chk("t4_done", 32'(done6), 32'd1);
    chk("t4_err_end", 32'(err6), 32'd0);
    chk("t4_bits_sent", 32'(bs6), 32'd6);
    chk("t4_parity", 32'(par6), 32'd0);

    // 20-bit chain, three back-to-back bytes, 4 bits of the last dropped
    start20 = 1'b1;
    @(posedge clk);
    #1;
    start20 = 1'b0;
    push_bits(8'hFF, 8, 20);
    push_bits(8'h00, 8, 20);
    push_bits(8'hF0, 4, 20);
    send_byte(8'hFF, 20);
    send_byte(8'h00, 20);
    send_byte(8'hF0, 20);
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("t2_ready_after_last", 32'(r20), 32'd0);
    for (int k = 0; k < 60 && !done20; k++) begin
      @(posedge clk);
      #1;
    end
    chk("t2_done", 32'(done20), 32'd1);
    chk("t2_bits_sent", 32'(bs20), 32'd20);
    chk("t2_shift_count", 32'(sh20_cnt), 32'd20);
    chk("t2_shift_span", 32'(sh20_last - sh20_first + 1), 32'd20);
    chk("t2_queue_empty", 32'(exp20_q.size()), 32'd0);

    // reset mid-load after three bits; start inside LOAD ignored
    pulse_start6();
    push_bits(8'hB4, 3, 6);
    send_byte(8'hB4, 6);
    cfg_valid = 1'b0;
    start6 = 1'b1;
    @(posedge clk);
    #1;
    start6 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("t5_bits_before_reset", 32'(bs6), 32'd3);
    chk("t5_busy_before_reset", 32'(busy6), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("t5_reset");
    rst = 1'b0;
    cfg_data = 8'hFF;
    cfg_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_idle_ready", 32'(r6), 32'd0);
      chk("t5_idle_shift", 32'(se6), 32'd0);
    end
    cfg_valid = 1'b0;
    chk("t5_idle_bits", 32'(bs6), 32'd0);
    chk("t5_idle_busy", 32'(busy6), 32'd0);
    chk("t5_idle_state", 32'(st6), 32'd0);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
